lfsr_dither_gen: RTL and testbench
==================================

# lfsr_dither_gen

Parametrised pseudo-random dither source for the delta-sigma modulator datapath, superseding the fixed 20-bit LFSR. It steps one or two maximal-length Fibonacci LFSRs on demand and emits a registered signed dither sample with a valid strobe. Runtime seed loading, zero-seed lock-up protection and a full-period marker are included. An optional triangular (TPDF) mode sums two uncorrelated sequences.

## Interface
- WIDTH, 20, LFSR length in bits; supported range 8..32.
- TAPS, 20'h90000, feedback mask (bit k set = tap on state[k]); default is x^20+x^17+1.
- OUT_WIDTH, 20, output sample width, 2 ≤ OUT_WIDTH ≤ WIDTH.
- SEED, 20'h00001, nonzero reset/fallback seed, WIDTH bits.
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  advance the sequence by one step this cycle.
- seed_load  input  1  load seed_i this cycle; has priority over enable.
- seed_i  input  WIDTH  new seed for LFSR A.
- mode_i  input  1  0 = uniform (RPDF), 1 = triangular (TPDF); sampled on each step.
- lfsr_o  output  OUT_WIDTH  signed dither sample.
- valid_o  output  1  one-cycle strobe: lfsr_o updated by the previous step.
- period_o  output  1  strobe with valid_o when LFSR A returns to its reference seed.
- lockup_o  output  1  sticky flag: a zero seed was rejected.

## Operation
- Step function per LFSR: next = {s[WIDTH-2:0], ^(s & TAPS)}.
- Registers: state_a, state_b (TPDF only), ref_seed, lfsr_o, valid_o, period_o, lockup_o.
- Reset: state_a = SEED, state_b = ~SEED (WIDTH bits), ref_seed = SEED, lfsr_o = 0, valid_o = 0, period_o = 0, lockup_o = 0.
- seed_load = 1: if seed_i ≠ 0, state_a = ref_seed = seed_i, state_b = ~seed_i, and lockup_o cleared. If seed_i = 0 (or ~seed_i = 0 for state_b), SEED/~SEED is substituted for the zero register and lockup_o is set. No step occurs and valid_o = 0 that cycle. If seed_i is all-ones, state_b takes ~SEED instead of 0.
- enable = 1 without seed_load: both LFSRs step. Output is computed from the next state and registered:
  - Uniform: lfsr_o = next_a[WIDTH-1 -: OUT_WIDTH] as two's complement.
  - Triangular: each top slice is sign-extended to OUT_WIDTH+1, the two are summed, then arithmetic right-shifted by 1 and truncated to OUT_WIDTH.
- Idle (enable = 0): state and lfsr_o hold; valid_o = 0; period_o = 0.
- period_o = 1 on a step where next_a == ref_seed; there are 2^WIDTH−1 steps per period for a maximal TAPS.
- LFSR state can never be zero, so no lock-up recovery is needed beyond seed substitution.

## Timing
- Latency: an enable at edge N updates lfsr_o and raises valid_o (and period_o if applicable), visible after edge N; both strobes drop after edge N+1 unless enable is held.
- Continuous enable gives one new sample every cycle, with valid_o held high.
- seed_load and enable in the same cycle: load only, no step, valid_o = 0.
- A mode_i change takes effect on the next step; there is no pipeline flush.
- Asserting reset mid-sequence clears all outputs immediately, independent of clock; the first step after release starts from SEED.

## Configuration
- LFSR_TPDF_EN defined: state_b and the summing path are present and mode_i selects RPDF/TPDF.
- LFSR_TPDF_EN undefined: state_b and the adder are removed, mode_i is ignored, and output is always uniform. All other behaviour is identical.

## Test plan
- Reset then 3 enables (defaults, uniform): lfsr_o = 2, 4, 8 with valid_o high each cycle. After 17 steps from reset, lfsr_o = 20'h20001.
- seed_load with seed_i = 20'h80000, then 1 enable: lfsr_o = 1; lockup_o = 0.
- seed_load with seed_i = 0: lockup_o = 1 and state_a = 20'h00001. A following valid load of 20'h00005 clears lockup_o.
- 1048575 consecutive enables after reset: period_o pulses only on the last one; lfsr_o = 1 at that point.
- TPDF (macro defined, mode_i = 1), first step after reset: A = 2, B = 20'hFFFFC (−4), so lfsr_o = −1 (20'hFFFFF).
- seed_load and enable together, then reset asserted mid-run: no valid_o on the load cycle; all outputs read 0 asynchronously during reset.

Source files
------------

// File: rtl/lfsr_dither_gen.sv
// lfsr_dither_gen: Fibonacci LFSR dither source with seed load, zero-seed guard and period marker.
// Define LFSR_TPDF_EN to add a second LFSR and the triangular (TPDF) summing path.
module lfsr_dither_gen #(
  parameter int WIDTH = 20,
  parameter logic [WIDTH-1:0] TAPS = 20'h90000,
  parameter int OUT_WIDTH = 20,
  parameter logic [WIDTH-1:0] SEED = 20'h00001
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_i,
  input  logic                 mode_i,
  output logic [OUT_WIDTH-1:0] lfsr_o,
  output logic                 valid_o,
  output logic                 period_o,
  output logic                 lockup_o
);
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction
  logic [WIDTH-1:0] state_a, ref_seed, next_a, load_a;
  logic [OUT_WIDTH-1:0] slice_a, sample;
  logic go, bad_seed;
  assign go = enable & ~seed_load;
  assign next_a = step(state_a);
  assign slice_a = next_a[WIDTH-1 -: OUT_WIDTH];
  assign load_a = (seed_i == '0) ? SEED : seed_i;
`ifdef LFSR_TPDF_EN
  logic [WIDTH-1:0] state_b, next_b, load_b;
  logic [OUT_WIDTH-1:0] slice_b;
  logic signed [OUT_WIDTH:0] sum;
  assign next_b = step(state_b);
  assign slice_b = next_b[WIDTH-1 -: OUT_WIDTH];
  assign sum = $signed({slice_a[OUT_WIDTH-1], slice_a}) + $signed({slice_b[OUT_WIDTH-1], slice_b});
  assign sample = mode_i ? OUT_WIDTH'(sum >>> 1) : slice_a;
  // an all-ones seed would leave state_b at zero, so it is rejected the same way
  assign load_b = (&seed_i) ? ~SEED : ~seed_i;
  assign bad_seed = (seed_i == '0) || (&seed_i);
  always_ff @(posedge clock or negedge reset)
    if (!reset) state_b <= ~SEED;
    else if (seed_load) state_b <= load_b;
    else if (enable) state_b <= next_b;
`else
  logic unused;
  assign unused = mode_i;
  assign sample = slice_a;
  assign bad_seed = seed_i == '0;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_a <= SEED;
      ref_seed <= SEED;
      lfsr_o <= '0;
      valid_o <= 1'b0;
      period_o <= 1'b0;
      lockup_o <= 1'b0;
    end else begin
      valid_o <= go;
      period_o <= go && (next_a == ref_seed);
      if (seed_load) begin
        state_a <= load_a;
        ref_seed <= load_a;
        lockup_o <= bad_seed;
      end else if (enable) begin
        state_a <= next_a;
        lfsr_o <= sample;
      end
    end
endmodule

// File: tb/tb_lfsr_dither_gen.sv
// tb_lfsr_dither_gen: directed checks of stepping, seeding, lock-up guard, TPDF, async reset and period marker.
module tb_lfsr_dither_gen;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b0, seed_load = 1'b0, mode_i = 1'b0;
  logic [19:0] seed_i = '0;
  logic [19:0] lfsr_o;
  logic valid_o, period_o, lockup_o;
  logic s_en = 1'b0;
  logic [7:0] s_lfsr;
  logic s_valid, s_period, s_lockup;
  int checks = 0, errors = 0;

  lfsr_dither_gen dut (
    .clock(clock), .reset(reset), .enable(enable), .seed_load(seed_load), .seed_i(seed_i),
    .mode_i(mode_i), .lfsr_o(lfsr_o), .valid_o(valid_o), .period_o(period_o), .lockup_o(lockup_o)
  );

  // 8-bit instance (x^8+x^6+x^5+x^4+1) so a full period fits in the run
  lfsr_dither_gen #(.WIDTH(8), .TAPS(8'hB8), .OUT_WIDTH(8), .SEED(8'h01)) dut8 (
    .clock(clock), .reset(reset), .enable(s_en), .seed_load(1'b0), .seed_i(8'h00),
    .mode_i(1'b0), .lfsr_o(s_lfsr), .valid_o(s_valid), .period_o(s_period), .lockup_o(s_lockup)
  );

  always #5 clock = ~clock;

  task automatic clk1(input logic en, input logic ld, input logic [19:0] s);
    enable = en; seed_load = ld; seed_i = s;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (lfsr_o !== 20'h0) begin errors++; $display("FAIL reset_lfsr got %h exp %h", lfsr_o, 20'h0); end
    checks++; if ({valid_o, period_o, lockup_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {valid_o, period_o, lockup_o}); end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
  endtask

  task automatic test_uniform();
    logic [19:0] exp_v [3] = '{20'h2, 20'h4, 20'h8};
    for (int i = 0; i < 3; i++) begin
      clk1(1'b1, 1'b0, '0);
      checks++; if (lfsr_o !== exp_v[i] || valid_o !== 1'b1) begin errors++; $display("FAIL uniform_step%0d got %h/%b exp %h/1", i, lfsr_o, valid_o, exp_v[i]); end
    end
    repeat (14) clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== 20'h20001) begin errors++; $display("FAIL step17 got %h exp 20001", lfsr_o); end
    clk1(1'b0, 1'b0, '0);
    checks++; if (valid_o !== 1'b0 || lfsr_o !== 20'h20001) begin errors++; $display("FAIL idle_hold got %h/%b exp 20001/0", lfsr_o, valid_o); end
  endtask

  task automatic test_seed_load();
    clk1(1'b1, 1'b1, 20'h80000);
    checks++; if (valid_o !== 1'b0 || lfsr_o !== 20'h20001) begin errors++; $display("FAIL load_with_enable got %h/%b exp 20001/0", lfsr_o, valid_o); end
    clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== 20'h1 || lockup_o !== 1'b0 || valid_o !== 1'b1) begin errors++; $display("FAIL load_80000 got %h/%b/%b exp 1/0/1", lfsr_o, lockup_o, valid_o); end
  endtask

  task automatic test_lockup();
    clk1(1'b0, 1'b1, 20'h0);
    checks++; if (lockup_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL zero_seed got %b/%b exp 1/0", lockup_o, valid_o); end
    clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== 20'h2 || period_o !== 1'b0) begin errors++; $display("FAIL zero_seed_subst got %h/%b exp 2/0", lfsr_o, period_o); end
    clk1(1'b0, 1'b1, 20'h5);
    checks++; if (lockup_o !== 1'b0) begin errors++; $display("FAIL lockup_clear got %b exp 0", lockup_o); end
    clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== 20'hA) begin errors++; $display("FAIL load_5_step got %h exp a", lfsr_o); end
  endtask

  task automatic test_tpdf();
    logic [19:0] e1, e2;
`ifdef LFSR_TPDF_EN
    e1 = 20'hFFFFF; e2 = 20'hFFFFE;
`else
    e1 = 20'h2; e2 = 20'h4;
`endif
    reset = 1'b0; #1; reset = 1'b1;
    mode_i = 1'b1;
    clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== e1) begin errors++; $display("FAIL tpdf_step1 got %h exp %h", lfsr_o, e1); end
    clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== e2) begin errors++; $display("FAIL tpdf_step2 got %h exp %h", lfsr_o, e2); end
    mode_i = 1'b0;
    clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== 20'h8) begin errors++; $display("FAIL mode_switch got %h exp 8", lfsr_o); end
  endtask

  task automatic test_async_reset();
    clk1(1'b0, 1'b1, 20'h0);
    clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== 20'h2 || lockup_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset got %h/%b/%b exp 2/1/1", lfsr_o, lockup_o, valid_o); end
    reset = 1'b0; #2;
    checks++; if (lfsr_o !== 20'h0 || {valid_o, period_o, lockup_o} !== 3'b000) begin errors++; $display("FAIL async_reset got %h/%b exp 0/000", lfsr_o, {valid_o, period_o, lockup_o}); end
    @(negedge clock) reset = 1'b1;
    clk1(1'b1, 1'b0, '0);
    checks++; if (lfsr_o !== 20'h2) begin errors++; $display("FAIL post_reset got %h exp 2", lfsr_o); end
    clk1(1'b0, 1'b0, '0);
  endtask

  task automatic test_period();
    int early = 0;
    s_en = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      @(posedge clock); #1;
      if (i < 255 && s_period) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL period_early got %0d exp 0", early); end
    checks++; if (s_period !== 1'b1 || s_valid !== 1'b1 || s_lfsr !== 8'h01) begin errors++; $display("FAIL period_end got %b/%b/%h exp 1/1/01", s_period, s_valid, s_lfsr); end
    s_en = 1'b0;
    @(posedge clock); #1;
    checks++; if (s_period !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL period_drop got %b/%b exp 0/0", s_period, s_valid); end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_seed_load();
    test_lockup();
    test_tpdf();
    test_async_reset();
    test_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
